datapath: RTL and testbench
===========================

# datapath

32-bit bus-based processor datapath: 16 general registers plus HI, LO, PC, IR, MAR, MDR, Y, Z (64-bit) and INPORT, all joined by one 32-bit bus driven through a one-hot-to-code encoder and multiplexer. The block is steered cycle by cycle by an external control unit or testbench using per-register `in`/`out` strobes. It exposes every bus source and the encoder code for observation.

## Interface
- No parameters.
- `Clock`  in  1  rising-edge clock for all registers.
- `Clear`  in  1  synchronous, active-low reset.
- `R0in`…`R15in`, `HIin`, `LOin`, `PCin`, `MDRin`, `INPORTin`, `Yin`, `MARin`, `IRin`  in  1 each  load bus into the named register at the rising edge. `MDRin` loads from `Mdatain` instead when `Read`=1.
- `Zin`  in  1  load the 64-bit ALU result into Z.
- `AND`  in  1  ALU op select: Y & bus.
- `IncPC`  in  1  ALU op select: bus + 1.
- `Read`  in  1  MDR input mux: 1 selects `Mdatain`, 0 selects bus.
- `Mdatain`  in  32  memory read data.
- `R0out`…`R15out`, `HIout`, `LOout`, `ZHIout`, `ZLOout`, `PCout`, `MDRout`, `INPORTout`, `Yout`  in  1 each  drive the named source onto the bus.
- `Zout`  in  1  alias of `ZLOout`.
- `busMuxOut`  out  32  current bus value.
- `encoderOut`  out  5  selected source code.
- `BusMuxInR0`…`BusMuxInR15`, `BusMuxInHI`, `BusMuxInLO`, `BusMuxInZhi`, `BusMuxInZlo`, `BusMuxInPC`, `BusMuxInMDR`, `BusMuxInInport`, `BusMuxInY`  out  32 each  register contents.

## Operation
- Encoder codes: R0–R15 = 0–15, HI = 16, LO = 17, ZHI = 18, ZLO/Zout = 19, PC = 20, MDR = 21, INPORT = 22, Y = 23.
- If no `*out` strobe is asserted, code = 31 and bus = 0.
- If several strobes are asserted, the lowest code wins.
- Bus = the selected source; purely combinational.
- ALU op priority: `IncPC`, then `AND`, then decode of IR[31:27].
  - Base decode: 10001 = NOT (~bus).
  - Any other opcode = pass-through (bus).
- ALU result width and Z loading:
  - All ops produce 32 bits.
  - Zlo receives the result and Zhi is loaded with 0.
  - Arithmetic wraps modulo 2^32.
- MAR and IR are internal only.
- The register file imposes no R0 special case.
- INPORT loads from the bus.

## Timing
- All register writes occur at the rising edge of `Clock` when the corresponding `in` strobe is high.
  - Writes have single-cycle latency.
  - Value is visible on `BusMuxIn*` after the edge.
- Read-during-write: a register driving the bus while its own `in` is asserted captures its old value (no change).
- `Clear`=0 at a rising edge resets every register (R0–R15, HI, LO, PC, IR, MAR, MDR, Y, Z, INPORT) to 0.
  - This overrides all `in` strobes, including mid-sequence.
- Reset outputs: every `BusMuxIn*` = 0, `busMuxOut` = 0, `encoderOut` = 31 (with no strobes asserted).
- No handshake and no internal state machine; sequencing is entirely the caller's responsibility.

## Configuration
- `DATAPATH_ALU_EXT_EN` defined: IR decode additionally supports:
  - 00011 ADD: Y + bus
  - 00100 SUB: Y − bus
  - 00101 AND
  - 00110 OR
  - 10000 NEG: −bus
  - 00111/01000 SHR/SHL: Y shifted by bus[4:0]
- Macro undefined: only NOT plus the `IncPC`/`AND` strobes; other opcodes pass the bus through.

## Test plan
- Register load: `Mdatain`=0x00000012, `Read`=1 and `MDRin`=1 for one edge, then `MDRout`+`R1in` for one edge → `BusMuxInR1`=0x00000012; `encoderOut`=21 during the transfer.
- Fetch: PC=0; `PCout`+`MARin`+`IncPC`+`Zin` → Zlo=1. Then `ZLOout`+`PCin` with `Read`+`MDRin`, `Mdatain`=0x88918000 → PC=1, MDR=0x88918000. Then `MDRout`+`IRin` → IR loaded.
- NOT: with IR=0x88918000, `R1out`+`Zin` → Zlo=0xFFFFFFED, Zhi=0, `encoderOut`=1. Then `ZLOout`+`R0in` → `BusMuxInR0`=0xFFFFFFED.
- AND: Y=0x0000F0F0, bus=0x00000FF0 with `AND`+`Zin` → Zlo=0x000000F0.
- Idle bus and priority: no strobes → bus=0, code=31. `R2out`+`PCout` together → R2 drives the bus, code=2.
- Reset: load R5=0xDEADBEEF, assert `Clear`=0 for one edge while `R5in`=1 → R5=0 and all `BusMuxIn*`=0.

Source files
------------

// File: rtl/datapath.sv
// Bus-based 32-bit processor datapath: register file, special registers, encoder/bus mux and ALU into Z.
// Optional IR opcodes (ADD/SUB/AND/OR/NEG/SHR/SHL) are enabled by defining DATAPATH_ALU_EXT_EN.
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, PCin, MDRin, INPORTin, Yin, MARin, IRin, Zin,
  input  logic        AND, IncPC, Read,
  input  logic [31:0] Mdatain,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Zout,
  output logic [31:0] busMuxOut,
  output logic [4:0]  encoderOut,
  output logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
  output logic [31:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
  output logic [31:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
  output logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [31:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
  output logic [31:0] BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInY
);

  localparam int unsigned W      = 32;
  localparam int unsigned NREG   = 16;
  localparam int unsigned NSRC   = 24;
  localparam int unsigned CW     = 5;
  localparam logic [CW-1:0] IDLE_CODE = 5'd31;

  logic [W-1:0] r [NREG];
  logic [W-1:0] hi, lo, pc, ir, mar, mdr, y, zhi, zlo, inport;
  logic [W-1:0] src [NSRC];
  logic [NREG-1:0] r_in;
  logic [NSRC-1:0] sel;
  logic [W-1:0] alu_res;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Zout is an alias of ZLOout and shares its code.
  assign sel = {Yout, INPORTout, MDRout, PCout, ZLOout | Zout, ZHIout, LOout, HIout,
                R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  always_comb begin
    for (int i = 0; i < 16; i++) src[i] = r[i];
    src[16] = hi;
    src[17] = lo;
    src[18] = zhi;
    src[19] = zlo;
    src[20] = pc;
    src[21] = mdr;
    src[22] = inport;
    src[23] = y;
  end

  // Priority encoder and bus mux: scan downward so the lowest asserted code wins.
  always_comb begin
    encoderOut = IDLE_CODE;
    busMuxOut  = '0;
    for (int i = 23; i >= 0; i--) begin
      if (sel[i]) begin
        encoderOut = CW'(i);
        busMuxOut  = src[i];
      end
    end
  end

  // ALU: strobes override the IR opcode decode.
  always_comb begin
    alu_res = busMuxOut;
    if (IncPC) begin
      alu_res = W'(busMuxOut + 32'd1);
    end else if (AND) begin
      alu_res = y & busMuxOut;
    end else begin
      case (ir[31:27])
        5'b10001: alu_res = ~busMuxOut;
`ifdef DATAPATH_ALU_EXT_EN
        5'b00011: alu_res = W'(y + busMuxOut);
        5'b00100: alu_res = W'(y - busMuxOut);
        5'b00101: alu_res = y & busMuxOut;
        5'b00110: alu_res = y | busMuxOut;
        5'b10000: alu_res = W'(32'd0 - busMuxOut);
        5'b00111: alu_res = y >> busMuxOut[4:0];
        5'b01000: alu_res = y << busMuxOut[4:0];
`endif
        default:  alu_res = busMuxOut;
      endcase
    end
  end

  // Register writes; the bus carries pre-edge values so read-during-write keeps the old value.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      hi     <= '0;
      lo     <= '0;
      pc     <= '0;
      ir     <= '0;
      mar    <= '0;
      mdr    <= '0;
      y      <= '0;
      zhi    <= '0;
      zlo    <= '0;
      inport <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (r_in[i]) r[i] <= busMuxOut;
      if (HIin)     hi     <= busMuxOut;
      if (LOin)     lo     <= busMuxOut;
      if (PCin)     pc     <= busMuxOut;
      if (IRin)     ir     <= busMuxOut;
      if (MARin)    mar    <= busMuxOut;
      if (MDRin)    mdr    <= Read ? Mdatain : busMuxOut;
      if (Yin)      y      <= busMuxOut;
      if (INPORTin) inport <= busMuxOut;
      if (Zin) begin
        zlo <= alu_res;
        zhi <= '0;
      end
    end
  end

  // MAR and the IR operand field have no consumer inside this block.
  logic unused;
  assign unused = ^{mar, ir[26:0]};

  assign BusMuxInR0  = r[0];
  assign BusMuxInR1  = r[1];
  assign BusMuxInR2  = r[2];
  assign BusMuxInR3  = r[3];
  assign BusMuxInR4  = r[4];
  assign BusMuxInR5  = r[5];
  assign BusMuxInR6  = r[6];
  assign BusMuxInR7  = r[7];
  assign BusMuxInR8  = r[8];
  assign BusMuxInR9  = r[9];
  assign BusMuxInR10 = r[10];
  assign BusMuxInR11 = r[11];
  assign BusMuxInR12 = r[12];
  assign BusMuxInR13 = r[13];
  assign BusMuxInR14 = r[14];
  assign BusMuxInR15 = r[15];
  assign BusMuxInHI     = hi;
  assign BusMuxInLO     = lo;
  assign BusMuxInZhi    = zhi;
  assign BusMuxInZlo    = zlo;
  assign BusMuxInPC     = pc;
  assign BusMuxInMDR    = mdr;
  assign BusMuxInInport = inport;
  assign BusMuxInY      = y;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: transfers, fetch, ALU ops, bus priority and reset.
module tb_datapath;

  logic Clock = 1'b0;
  logic Clear;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic HIin, LOin, PCin, MDRin, INPORTin, Yin, MARin, IRin, Zin;
  logic AND, IncPC, Read;
  logic [31:0] Mdatain;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Zout;
  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
  logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3;
  logic [31:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7;
  logic [31:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11;
  logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15;
  logic [31:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo;
  logic [31:0] BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInY;

  int compared = 0;
  int mismatched = 0;

  datapath dut (
    .Clock(Clock), .Clear(Clear),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
    .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in), .R11in(R11in),
    .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .INPORTin(INPORTin),
    .Yin(Yin), .MARin(MARin), .IRin(IRin), .Zin(Zin),
    .AND(AND), .IncPC(IncPC), .Read(Read), .Mdatain(Mdatain),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out), .R4out(R4out),
    .R5out(R5out), .R6out(R6out), .R7out(R7out), .R8out(R8out), .R9out(R9out),
    .R10out(R10out), .R11out(R11out), .R12out(R12out), .R13out(R13out),
    .R14out(R14out), .R15out(R15out),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Yout(Yout), .Zout(Zout),
    .busMuxOut(busMuxOut), .encoderOut(encoderOut),
    .BusMuxInR0(BusMuxInR0), .BusMuxInR1(BusMuxInR1), .BusMuxInR2(BusMuxInR2),
    .BusMuxInR3(BusMuxInR3), .BusMuxInR4(BusMuxInR4), .BusMuxInR5(BusMuxInR5),
    .BusMuxInR6(BusMuxInR6), .BusMuxInR7(BusMuxInR7), .BusMuxInR8(BusMuxInR8),
    .BusMuxInR9(BusMuxInR9), .BusMuxInR10(BusMuxInR10), .BusMuxInR11(BusMuxInR11),
    .BusMuxInR12(BusMuxInR12), .BusMuxInR13(BusMuxInR13), .BusMuxInR14(BusMuxInR14),
    .BusMuxInR15(BusMuxInR15),
    .BusMuxInHI(BusMuxInHI), .BusMuxInLO(BusMuxInLO), .BusMuxInZhi(BusMuxInZhi),
    .BusMuxInZlo(BusMuxInZlo), .BusMuxInPC(BusMuxInPC), .BusMuxInMDR(BusMuxInMDR),
    .BusMuxInInport(BusMuxInInport), .BusMuxInY(BusMuxInY)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in} = '0;
    {R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in} = '0;
    {HIin, LOin, PCin, MDRin, INPORTin, Yin, MARin, IRin, Zin} = '0;
    {AND, IncPC, Read} = '0;
    {R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out} = '0;
    {R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out} = '0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Zout} = '0;
  endtask

  // One rising edge, then release strobes and let combinational outputs settle.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
    #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    Clear = 1'b0;
    tick();
    Clear = 1'b1;
    chk("reset_bus", busMuxOut, 32'h0);
    chk("reset_code", 32'(encoderOut), 32'd31);
    chk("reset_r0", BusMuxInR0, 32'h0);
    chk("reset_pc", BusMuxInPC, 32'h0);
    chk("reset_zlo", BusMuxInZlo, 32'h0);

    // Memory data into MDR, then MDR to R1
    mdr_load(32'h0000_0012);
    chk("mdr_load", BusMuxInMDR, 32'h0000_0012);
    MDRout = 1'b1; R1in = 1'b1; #1;
    chk("mdr_code", 32'(encoderOut), 32'd21);
    chk("mdr_bus", busMuxOut, 32'h0000_0012);
    tick();
    chk("r1_load", BusMuxInR1, 32'h0000_0012);

    // Fetch: PC -> MAR, Z = PC + 1
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; #1;
    chk("pc_code", 32'(encoderOut), 32'd20);
    tick();
    chk("incpc_zlo", BusMuxInZlo, 32'h1);
    chk("incpc_zhi", BusMuxInZhi, 32'h0);
    ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h8891_8000; #1;
    chk("zlo_code", 32'(encoderOut), 32'd19);
    tick();
    chk("pc_inc", BusMuxInPC, 32'h1);
    chk("mdr_fetch", BusMuxInMDR, 32'h8891_8000);
    MDRout = 1'b1; IRin = 1'b1;
    tick();

    // NOT via IR opcode 10001, then Zout alias into R0
    R1out = 1'b1; Zin = 1'b1; #1;
    chk("not_code", 32'(encoderOut), 32'd1);
    tick();
    chk("not_zlo", BusMuxInZlo, 32'hFFFF_FFED);
    chk("not_zhi", BusMuxInZhi, 32'h0);
    Zout = 1'b1; R0in = 1'b1; #1;
    chk("zout_code", 32'(encoderOut), 32'd19);
    tick();
    chk("not_r0", BusMuxInR0, 32'hFFFF_FFED);

    // AND: Y=0xF0F0, bus=0x0FF0 from R3
    mdr_load(32'h0000_F0F0);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
    chk("y_load", BusMuxInY, 32'h0000_F0F0);
    mdr_load(32'h0000_0FF0);
    MDRout = 1'b1; R3in = 1'b1;
    tick();
    R3out = 1'b1; AND = 1'b1; Zin = 1'b1;
    tick();
    chk("and_zlo", BusMuxInZlo, 32'h0000_00F0);
    R3out = 1'b1; AND = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    tick();
    chk("incpc_over_and", BusMuxInZlo, 32'h0000_0FF1);

    // IR opcode 00000 passes the bus through
    R3out = 1'b1; IRin = 1'b1;
    tick();
    R3out = 1'b1; Zin = 1'b1;
    tick();
    chk("pass_zlo", BusMuxInZlo, 32'h0000_0FF0);

    // Idle bus and lowest-code priority
    #1;
    chk("idle_bus", busMuxOut, 32'h0);
    chk("idle_code", 32'(encoderOut), 32'd31);
    R3out = 1'b1; R2in = 1'b1;
    tick();
    R2out = 1'b1; PCout = 1'b1; #1;
    chk("prio_code", 32'(encoderOut), 32'd2);
    chk("prio_bus", busMuxOut, 32'h0000_0FF0);

    // Read-during-write on R2 while HI captures the same bus value
    R2out = 1'b1; R2in = 1'b1; HIin = 1'b1; R15in = 1'b1;
    tick();
    chk("rdw_r2", BusMuxInR2, 32'h0000_0FF0);
    chk("hi_load", BusMuxInHI, 32'h0000_0FF0);
    chk("r15_load", BusMuxInR15, 32'h0000_0FF0);
    R1out = 1'b1; INPORTin = 1'b1; LOin = 1'b1;
    tick();
    chk("inport_load", BusMuxInInport, 32'h0000_0012);
    chk("lo_load", BusMuxInLO, 32'h0000_0012);
    INPORTout = 1'b1; Yout = 1'b1; #1;
    chk("inport_code", 32'(encoderOut), 32'd22);
    chk("inport_bus", busMuxOut, 32'h0000_0012);
    idle(); Yout = 1'b1; #1;
    chk("y_code", 32'(encoderOut), 32'd23);
    idle(); HIout = 1'b1; LOout = 1'b1; #1;
    chk("hi_code", 32'(encoderOut), 32'd16);
    idle(); #1;

    // Reset overrides a concurrent write
    mdr_load(32'hDEAD_BEEF);
    MDRout = 1'b1; R5in = 1'b1;
    tick();
    chk("r5_load", BusMuxInR5, 32'hDEAD_BEEF);
    Clear = 1'b0; MDRout = 1'b1; R5in = 1'b1;
    tick();
    Clear = 1'b1;
    chk("clr_r5", BusMuxInR5, 32'h0);
    chk("clr_r0", BusMuxInR0, 32'h0);
    chk("clr_r15", BusMuxInR15, 32'h0);
    chk("clr_hi", BusMuxInHI, 32'h0);
    chk("clr_lo", BusMuxInLO, 32'h0);
    chk("clr_pc", BusMuxInPC, 32'h0);
    chk("clr_mdr", BusMuxInMDR, 32'h0);
    chk("clr_y", BusMuxInY, 32'h0);
    chk("clr_zlo", BusMuxInZlo, 32'h0);
    chk("clr_inport", BusMuxInInport, 32'h0);
    chk("clr_bus", busMuxOut, 32'h0);
    chk("clr_code", 32'(encoderOut), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
